// File: rtl/regfile_pkg.sv
// Shared constants, state encoding and ID type for the register-file access controller.
package regfile_pkg;

   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 3;
   localparam int DEPTH   = 2**ADDR_W;
   localparam int NUM_REQ = 4;
   localparam int RID_W   = $clog2(NUM_REQ);

   typedef logic [RID_W-1:0] rid_t;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/regfile_access_ctrl_rr_arbiter.sv
// Round-robin arbiter: the first asserted request at or after ptr (ascending, wrapping) wins.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant_onehot,
   output logic [IW-1:0] grant_idx,
   output logic          any_grant
);

   // One extra bit holds ptr+offset before the explicit modulo-N wrap.
   logic [IW:0]   w_sum  [N];
   logic [IW-1:0] w_cand [N];

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_cand
         assign w_sum[gi]  = {1'b0, ptr} + (IW+1)'(gi);
         assign w_cand[gi] = (w_sum[gi] >= (IW+1)'(N)) ? IW'(w_sum[gi] - (IW+1)'(N))
                                                         : IW'(w_sum[gi]);
      end
   endgenerate

   // Priority search over the rotated candidate order; the first valid candidate wins.
   always_comb begin
      grant_onehot = '0;
      grant_idx    = '0;
      any_grant    = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!any_grant && req[w_cand[k]]) begin
            any_grant               = 1'b1;
            grant_idx               = w_cand[k];
            grant_onehot[w_cand[k]] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Shares a single-port register file among NUM_REQ requesters with round-robin
// arbitration, an optional post-reset init walk and tagged read responses.
module regfile_access_ctrl #(
   parameter int                      NUM_REQ  = regfile_pkg::NUM_REQ,
   parameter int                      DATA_W   = regfile_pkg::DATA_W,
   parameter int                      ADDR_W   = regfile_pkg::ADDR_W,
   parameter bit                      INIT_EN  = 1'b1,
   parameter logic [DATA_W-1:0]       INIT_VAL = '0
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          rsp_valid,
   output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
   output logic [DATA_W-1:0]             rsp_rdata,
   output logic                          busy,
   output logic [DATA_W-1:0]             rf_WrData,
   output logic [ADDR_W-1:0]             rf_Address,
   output logic                          rf_WrEn,
   output logic                          rf_RdEn,
   input  logic [DATA_W-1:0]             rf_RdData
);

   import regfile_pkg::*;

   localparam int DEPTH = 2**ADDR_W;
   localparam int IW    = $clog2(NUM_REQ);

   state_t              r_state;
   state_t              w_state_next;
   logic [ADDR_W-1:0]   r_init_cnt;
   logic [IW-1:0]       r_rr_ptr;
   logic                r_rsp_valid;
   logic [IW-1:0]       r_rsp_id;

   logic [NUM_REQ-1:0]  w_arb_req;
   logic [NUM_REQ-1:0]  w_grant;
   logic [IW-1:0]       w_idx;
   logic                w_any;
   logic                w_run;
   logic                w_win_we;
   logic [ADDR_W-1:0]   w_win_addr;
   logic [DATA_W-1:0]   w_win_wdata;
   logic                w_rd_issue;

   logic [ADDR_W-1:0]   w_addr_arr  [NUM_REQ];
   logic [DATA_W-1:0]   w_wdata_arr [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign w_addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
         assign w_wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Requests are only visible to the arbiter in RUN and outside reset.
   assign w_run     = (r_state == ST_RUN) && !RST;
   assign w_arb_req = req_valid & {NUM_REQ{w_run}};

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req          (w_arb_req),
      .ptr          (r_rr_ptr),
      .grant_onehot (w_grant),
      .grant_idx    (w_idx),
      .any_grant    (w_any)
   );

   assign w_win_we    = req_we[w_idx];
   assign w_win_addr  = w_addr_arr[w_idx];
   assign w_win_wdata = w_wdata_arr[w_idx];
   assign w_rd_issue  = w_any && !w_win_we;

   // State register: reset restarts the init walk (or goes straight to RUN).
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= INIT_EN ? ST_INIT : ST_RUN;
      else     r_state <= w_state_next;
   end

   // Next state: leave INIT after the last entry has been written; RUN is terminal.
   always_comb begin
      w_state_next = r_state;
      if (r_state == ST_INIT && r_init_cnt == ADDR_W'(DEPTH-1))
         w_state_next = ST_RUN;
   end

   // Outputs: init walk drives the port in INIT, the arbitration winner drives it in RUN.
   always_comb begin
      req_ready  = '0;
      busy       = 1'b0;
      rf_WrEn    = 1'b0;
      rf_RdEn    = 1'b0;
      rf_Address = '0;
      rf_WrData  = '0;
      if (!RST) begin
         case (r_state)
            ST_INIT: begin
               busy       = 1'b1;
               rf_WrEn    = 1'b1;
               rf_Address = r_init_cnt;
               rf_WrData  = INIT_VAL;
            end
            default: begin
               if (w_any) begin
                  req_ready  = w_grant;
                  rf_WrEn    = w_win_we;
                  rf_RdEn    = !w_win_we;
                  rf_Address = w_win_addr;
                  rf_WrData  = w_win_wdata;
               end
            end
         endcase
      end
   end

   // Init counter advances once per INIT cycle and wraps to 0 on entry to RUN.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                      r_init_cnt <= '0;
      else if (r_state == ST_INIT)  r_init_cnt <= r_init_cnt + ADDR_W'(1);
   end

   // Round-robin pointer moves to the requester after the winner, wrapping explicitly.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         r_rr_ptr <= '0;
      else if (w_any)
         r_rr_ptr <= (w_idx == IW'(NUM_REQ-1)) ? '0 : w_idx + IW'(1);
   end

   // Response tag: a read granted this cycle is answered next cycle with the winner's ID.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
      end else begin
         r_rsp_valid <= w_rd_issue;
         if (w_rd_issue) r_rsp_id <= w_idx;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_rdata = r_rsp_valid ? rf_RdData : '0;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: directed vector table, hand-written reset/init
// sequences and constrained-random traffic checked against a behavioural model.
module tb_regfile_access_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [3:0]  req_we    = '0;
   logic [11:0] req_addr  = '0;
   logic [63:0] req_wdata = '0;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_rdata;
   logic        busy;
   logic [15:0] rf_WrData;
   logic [2:0]  rf_Address;
   logic        rf_WrEn;
   logic        rf_RdEn;
   logic [15:0] rf_RdData;

   always #5 CLK = ~CLK;

   regfile_access_ctrl #(
      .NUM_REQ(4), .DATA_W(16), .ADDR_W(3), .INIT_EN(1'b1), .INIT_VAL(16'hA5A5)
   ) dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
      .busy(busy), .rf_WrData(rf_WrData), .rf_Address(rf_Address),
      .rf_WrEn(rf_WrEn), .rf_RdEn(rf_RdEn), .rf_RdData(rf_RdData)
   );

   // Register-file instance stand-in: synchronous write, registered read.
   logic [15:0] rf_mem [8];
   logic [15:0] rf_q = '0;
   initial for (int i = 0; i < 8; i++) rf_mem[i] <= 16'($urandom);
   always @(posedge CLK) begin
      if (rf_WrEn) rf_mem[rf_Address] <= rf_WrData;
      if (rf_RdEn) rf_q <= rf_mem[rf_Address];
   end
   assign rf_RdData = rf_q;

   int n_pass = 0;
   int n_tot  = 0;

   // Behavioural model: contents, pointer, and the response owed next cycle.
   logic [15:0] m_mem [8];
   int          m_ptr   = 0;
   bit          m_pend  = 0;
   int          m_pid   = 0;
   logic [15:0] m_pdata = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_mem[i] = 16'hA5A5;
      m_ptr = 0; m_pend = 0;
   endtask

   // One clock of traffic: drive at negedge, check the issue and last cycle's response, update model.
   task automatic cycle(input logic [3:0] v, input logic [3:0] we, input logic [11:0] a,
                        input logic [63:0] wd, input bit use_tab, input logic [3:0] tab_rdy,
                        input string tag, output int win);
      logic [3:0]  exp_rdy;
      logic [2:0]  ea;
      logic [15:0] ew;
      int j;
      @(negedge CLK);
      req_valid = v; req_we = we; req_addr = a; req_wdata = wd;
      #1;
      win = -1;
      for (int k = 0; k < 4; k++) begin
         j = (m_ptr + k) % 4;
         if (win < 0 && v[j]) win = j;
      end
      exp_rdy = (win < 0) ? 4'b0000 : 4'(1 << win);
      chk({tag, " ready"}, req_ready, use_tab ? tab_rdy : exp_rdy);
      ea = '0; ew = '0;
      if (win < 0) begin
         chk({tag, " wren"}, rf_WrEn, 0);
         chk({tag, " rden"}, rf_RdEn, 0);
      end else begin
         ea = a[win*3 +: 3];
         ew = wd[win*16 +: 16];
         chk({tag, " wren"}, rf_WrEn, we[win]);
         chk({tag, " rden"}, rf_RdEn, !we[win]);
         chk({tag, " addr"}, rf_Address, ea);
         chk({tag, " wdata"}, rf_WrData, ew);
      end
      chk({tag, " rsp_valid"}, rsp_valid, m_pend);
      if (m_pend) begin
         chk({tag, " rsp_id"}, rsp_id, m_pid);
         chk({tag, " rsp_rdata"}, rsp_rdata, m_pdata);
      end else begin
         chk({tag, " rsp_rdata_idle"}, rsp_rdata, 0);
      end
      m_pend = 0;
      if (win >= 0) begin
         if (we[win]) m_mem[ea] = ew;
         else begin m_pend = 1; m_pid = win; m_pdata = m_mem[ea]; end
         m_ptr = (win + 1) % 4;
      end
   endtask

   // Entered at negedge+1 with the controller in INIT at count 0; leaves at negedge+1 in RUN.
   task automatic init_walk(input string tag);
      for (int c = 0; c < 8; c++) begin
         chk($sformatf("%s busy c%0d", tag, c), busy, 1);
         chk($sformatf("%s ready c%0d", tag, c), req_ready, 0);
         chk($sformatf("%s wren c%0d", tag, c), rf_WrEn, 1);
         chk($sformatf("%s rden c%0d", tag, c), rf_RdEn, 0);
         chk($sformatf("%s addr c%0d", tag, c), rf_Address, c);
         chk($sformatf("%s wdata c%0d", tag, c), rf_WrData, 16'hA5A5);
         if (c == 7) req_valid = '0;
         @(negedge CLK); #1;
      end
      chk({tag, " busy_done"}, busy, 0);
      model_reset();
   endtask

   typedef struct {
      logic [3:0]  v;
      logic [3:0]  we;
      logic [11:0] a;
      logic [63:0] wd;
      logic [3:0]  rdy;
   } vec_t;

   localparam int NT = 23;
   vec_t tab [NT];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int w;
      logic [3:0]  rv, rwe;
      logic [11:0] ra;
      logic [63:0] rwd;

      // Directed vectors, starting from pointer 0 with every entry holding A5A5.
      tab[0] = '{4'b1000, 4'b0000, {3'd5, 9'd0}, 64'd0, 4'b1000};
      for (int i = 1; i <= 5; i++)
         tab[i] = '{4'b1111, 4'b0000, {3'd3, 3'd2, 3'd1, 3'd0}, 64'd0, 4'(1 << ((i-1) % 4))};
      tab[6] = '{4'b0010, 4'b0010, {3'd0, 3'd0, 3'd2, 3'd0}, {16'h0, 16'h0, 16'h1234, 16'h0}, 4'b0010};
      tab[7] = '{4'b1000, 4'b0000, {3'd2, 9'd0}, 64'd0, 4'b1000};
      tab[8] = '{4'b0010, 4'b0000, {3'd0, 3'd0, 3'd7, 3'd0}, 64'd0, 4'b0010};
      tab[9] = '{4'b0011, 4'b0000, {3'd0, 3'd0, 3'd1, 3'd4}, 64'd0, 4'b0001};
      tab[10] = '{4'b0011, 4'b0000, {3'd0, 3'd0, 3'd1, 3'd4}, 64'd0, 4'b0010};
      for (int i = 11; i <= 20; i++) tab[i] = '{4'b0000, 4'b0000, 12'd0, 64'd0, 4'b0000};
      tab[21] = '{4'b1111, 4'b0000, {3'd6, 3'd5, 3'd4, 3'd3}, 64'd0, 4'b0100};
      tab[22] = '{4'b0000, 4'b0000, 12'd0, 64'd0, 4'b0000};

      // Reset state, with every requester asserting valid.
      RST = 1'b1; req_valid = 4'hF;
      repeat (3) @(negedge CLK);
      #1;
      chk("rst busy", busy, 0);
      chk("rst ready", req_ready, 0);
      chk("rst wren", rf_WrEn, 0);
      chk("rst rden", rf_RdEn, 0);
      chk("rst addr", rf_Address, 0);
      chk("rst wdata", rf_WrData, 0);
      chk("rst rsp_valid", rsp_valid, 0);
      chk("rst rsp_id", rsp_id, 0);
      chk("rst rsp_rdata", rsp_rdata, 0);

      @(negedge CLK);
      RST = 1'b0;
      #1;
      init_walk("init");

      for (int n = 0; n < NT; n++)
         cycle(tab[n].v, tab[n].we, tab[n].a, tab[n].wd, 1'b1, tab[n].rdy, $sformatf("vec%0d", n), w);

      // Random traffic; a requester keeps its request stable until granted.
      rv = '0; rwe = '0; ra = '0; rwd = '0;
      for (int t = 0; t < 400; t++) begin
         for (int i = 0; i < 4; i++) begin
            if (!rv[i] && $urandom_range(0, 2) != 0) begin
               rv[i] = 1'b1;
               rwe[i] = 1'($urandom_range(0, 1));
               ra[i*3 +: 3] = 3'($urandom_range(0, 7));
               rwd[i*16 +: 16] = 16'($urandom);
            end
         end
         cycle(rv, rwe, ra, rwd, 1'b0, 4'b0000, "rand", w);
         if (w >= 0) rv[w] = 1'b0;
      end
      cycle(4'b0000, 4'b0000, 12'd0, 64'd0, 1'b0, 4'b0000, "drain", w);

      // Reset in the middle of the init walk restarts the walk from entry 0.
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0; req_valid = 4'hF;
      #1;
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("mid addr c%0d", c), rf_Address, c);
         @(negedge CLK); #1;
      end
      chk("mid addr c4", rf_Address, 4);
      RST = 1'b1;
      #1;
      chk("mid rst busy", busy, 0);
      chk("mid rst wren", rf_WrEn, 0);
      chk("mid rst ready", req_ready, 0);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      init_walk("reinit");

      // Contents rewritten by the second walk.
      cycle(4'b0001, 4'b0000, {9'd0, 3'd5}, 64'd0, 1'b1, 4'b0001, "post read", w);
      cycle(4'b0000, 4'b0000, 12'd0, 64'd0, 1'b1, 4'b0000, "post rsp", w);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
